// File: rtl/cm3_reset_pkg.sv
// Shared types for the CM3 reset sequencer: sequencer states, reset causes
// and the counter-width helper.
package cm3_reset_pkg;

    typedef enum logic [1:0] {
        POR      = 2'd0,
        CPU_WAIT = 2'd1,
        RUN      = 2'd2,
        SYS_RST  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR    = 2'd0,
        CAUSE_BTN    = 2'd1,
        CAUSE_SYSREQ = 2'd2,
        CAUSE_LOCKUP = 2'd3
    } cause_t;

    // Bits needed to hold the largest of three terminal counts.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/cm3_debounce.sv
// Pushbutton path: 2-flop synchroniser followed by a stability-count debouncer.
// The debounced level follows the synced input only after it has differed for DEBOUNCE_CYCLES cycles.
module cm3_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_db_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_db_o = db_q;

endmodule

// File: rtl/cm3_reset_ctrl.sv
// CM3 reset sequencer: staged POR/CPU reset release, button and SYSRESETREQ handling, cause log.
// Define RESET_LOCKUP_EN to also reset the CPU after LOCKUP_CYCLES consecutive LOCKUP cycles.
module cm3_reset_ctrl
    import cm3_reset_pkg::*;
#(
    parameter int PO_HOLD         = 245,
    parameter int CPU_DELAY       = 10,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int LOCKUP_CYCLES   = 1024
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       BTN,
    input  logic       SYSRESETREQ,
    input  logic       LOCKUP,
    output logic       poreset_n,
    output logic       cpureset_n,
    output logic [1:0] reset_cause
);

    localparam int CNT_W = cnt_width(PO_HOLD, CPU_DELAY, LOCKUP_CYCLES);

    state_t           state_q, state_d;
    cause_t           cause_q, cause_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             por_q, por_d, cpu_q, cpu_d;
    logic             btn_db, btn_db_q, btn_rise;
    logic             lk_trig;

    cm3_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk_i   (CLK),
        .rst_ni  (RESETn),
        .btn_i   (BTN),
        .btn_db_o(btn_db)
    );

    assign btn_rise = btn_db & ~btn_db_q;

`ifdef RESET_LOCKUP_EN
    logic [CNT_W-1:0] lk_q, lk_d;

    assign lk_trig = (state_q == RUN) && LOCKUP && (lk_q == CNT_W'(LOCKUP_CYCLES - 1));

    // Counts only consecutive LOCKUP cycles while staying in RUN.
    always_comb begin
        lk_d = '0;
        if (state_d == RUN && LOCKUP) lk_d = lk_q + CNT_W'(1);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) lk_q <= '0;
        else         lk_q <= lk_d;
    end
`else
    logic unused_lockup;
    assign unused_lockup = LOCKUP;
    assign lk_trig       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        if (btn_rise) begin
            state_d = POR;
            cnt_d   = '0;
            cause_d = CAUSE_BTN;
        end else begin
            case (state_q)
                POR: begin
                    if (btn_db) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_W'(PO_HOLD - 1)) begin
                        state_d = CPU_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CPU_WAIT, SYS_RST: begin
                    if (cnt_q == CNT_W'(CPU_DELAY - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (SYSRESETREQ) begin
                        state_d = SYS_RST;
                        cnt_d   = '0;
                        cause_d = CAUSE_SYSREQ;
                    end else if (lk_trig) begin
                        state_d = SYS_RST;
                        cnt_d   = '0;
                        cause_d = CAUSE_LOCKUP;
                    end
                end
                default: begin
                    state_d = POR;
                    cnt_d   = '0;
                end
            endcase
        end
        // Outputs are registered from the next state so they move on the transition edge.
        por_d = (state_d != POR);
        cpu_d = (state_d == RUN);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= POR;
            cnt_q    <= '0;
            cause_q  <= CAUSE_POR;
            por_q    <= 1'b0;
            cpu_q    <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cause_q  <= cause_d;
            por_q    <= por_d;
            cpu_q    <= cpu_d;
            btn_db_q <= btn_db;
        end
    end

    assign poreset_n   = por_q;
    assign cpureset_n  = cpu_q;
    assign reset_cause = cause_q;

endmodule
